// File: rtl/fib_step_controller.sv
// Run/step sequencer for the 8-bit Fibonacci register pair: debounced board keys,
// prescaled auto-step, and restart from {1,1} at the term limit or on adder overflow.

module fib_key_debounce #(
  parameter int DEBOUNCE_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic press_o
);

  logic                  sync1_q;
  logic                  sync2_q;
  logic                  level_q, level_d;
  logic                  press_q, press_d;
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter only runs while the synchronised key disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == '1) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

module fib_step_controller #(
  parameter int TICK_W     = 25,
  parameter int DEBOUNCE_W = 16,
  parameter int TERM_W     = 5,
  parameter int MAX_TERMS  = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_run_n_i,
  input  logic              key_step_n_i,
  input  logic              carry_in_i,
  output logic              step_en_o,
  output logic              seed_load_o,
  output logic              running_o,
  output logic [TERM_W-1:0] term_idx_o
);

  typedef enum logic [1:0] {INIT, PAUSED, RUNNING, WRAP} state_e;

  localparam logic [TERM_W-1:0] LAST_TERM = TERM_W'(MAX_TERMS - 1);

  state_e              state_q, state_d;
  logic                retRun_q, retRun_d;
  logic [TICK_W-1:0]   presc_q, presc_d;
  logic [TERM_W-1:0]   term_q, term_d;
  logic                stepEn_q, stepEn_d;
  logic                seedLoad_q, seedLoad_d;
  logic                running_q, running_d;
  logic                runPress, stepPress;
  logic                tick, stepReq, wrapNeeded;

  fib_key_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) uRunKey (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_run_n_i),
    .press_o (runPress)
  );

  fib_key_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) uStepKey (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_step_n_i),
    .press_o (stepPress)
  );

  assign tick       = (state_q == RUNNING) && (presc_q == '1);
  assign wrapNeeded = carry_in_i || (term_q == LAST_TERM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      retRun_q   <= 1'b0;
      presc_q    <= '0;
      term_q     <= '0;
      stepEn_q   <= 1'b0;
      seedLoad_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      retRun_q   <= retRun_d;
      presc_q    <= presc_d;
      term_q     <= term_d;
      stepEn_q   <= stepEn_d;
      seedLoad_q <= seedLoad_d;
      running_q  <= running_d;
    end
  end

  // Run press has priority over both a step press and a tick in the same cycle.
  always_comb begin
    state_d  = state_q;
    retRun_d = retRun_q;
    stepReq  = 1'b0;
    case (state_q)
      INIT:    state_d = PAUSED;
      PAUSED: begin
        if (runPress)       state_d = RUNNING;
        else if (stepPress) stepReq = 1'b1;
      end
      RUNNING: begin
        if (runPress)  state_d = PAUSED;
        else if (tick) stepReq = 1'b1;
      end
      WRAP:    state_d = retRun_q ? RUNNING : PAUSED;
      default: state_d = INIT;
    endcase
    if (stepReq && wrapNeeded) begin
      state_d  = WRAP;
      retRun_d = (state_q == RUNNING);
    end
  end

  always_comb begin
    stepEn_d   = stepReq && !wrapNeeded;
    seedLoad_d = (state_q == INIT) || (stepReq && wrapNeeded);
    term_d     = term_q;
    if (seedLoad_d)    term_d = '0;
    else if (stepEn_d) term_d = term_q + 1'b1;
    running_d  = (state_d == RUNNING) || ((state_d == WRAP) && retRun_d);
    presc_d    = (state_q == RUNNING) ? presc_q + 1'b1 : '0;
  end

  assign step_en_o   = stepEn_q;
  assign seed_load_o = seedLoad_q;
  assign running_o   = running_q;
  assign term_idx_o  = term_q;

endmodule

// File: tb/tb_fib_step_controller.sv
// Directed bench for fib_step_controller with short prescaler and debounce
// (TICK_W=3, DEBOUNCE_W=2, MAX_TERMS=13).

module tb_fib_step_controller;

  localparam int TERM_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              keyRunN = 1'b1;
  logic              keyStepN = 1'b1;
  logic              carryIn = 1'b0;
  logic              stepEn;
  logic              seedLoad;
  logic              running;
  logic [TERM_W-1:0] termIdx;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  fib_step_controller #(
    .TICK_W     (3),
    .DEBOUNCE_W (2),
    .TERM_W     (TERM_W),
    .MAX_TERMS  (13)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_run_n_i  (keyRunN),
    .key_step_n_i (keyStepN),
    .carry_in_i   (carryIn),
    .step_en_o    (stepEn),
    .seed_load_o  (seedLoad),
    .running_o    (running),
    .term_idx_o   (termIdx)
  );

  task automatic test_reset();
    int seeds = 0;
    int steps = 0;
    rst = 1'b1; keyRunN = 1'b1; keyStepN = 1'b1; carryIn = 1'b0;
    repeat (5) @(negedge clk);
    testsRun++; if (stepEn !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_step_en: got %b expected 0", stepEn); end
    testsRun++; if (seedLoad !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_seed_load: got %b expected 0", seedLoad); end
    testsRun++; if (running !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_running: got %b expected 0", running); end
    testsRun++; if (termIdx !== 5'd0) begin testsFailed++; $display("[TB] FAIL reset_term_idx: got %0d expected 0", termIdx); end
    rst = 1'b0;
    @(negedge clk);
    testsRun++; if (seedLoad !== 1'b1) begin testsFailed++; $display("[TB] FAIL init_seed: got %b expected 1", seedLoad); end
    testsRun++; if (running !== 1'b0) begin testsFailed++; $display("[TB] FAIL init_running: got %b expected 0", running); end
    repeat (100) begin
      @(negedge clk);
      if (seedLoad === 1'b1) seeds++;
      if (stepEn === 1'b1) steps++;
    end
    testsRun++; if (seeds != 0) begin testsFailed++; $display("[TB] FAIL init_seed_once: got %0d extra seed cycles expected 0", seeds); end
    testsRun++; if (steps != 0) begin testsFailed++; $display("[TB] FAIL init_no_step: got %0d step cycles expected 0", steps); end
    testsRun++; if (termIdx !== 5'd0) begin testsFailed++; $display("[TB] FAIL init_term_idx: got %0d expected 0", termIdx); end
  endtask

  task automatic test_single_step();
    int steps = 0;
    int seeds = 0;
    keyStepN = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (stepEn === 1'b1) steps++;
      if (seedLoad === 1'b1) seeds++;
    end
    keyStepN = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (stepEn === 1'b1) steps++;
      if (seedLoad === 1'b1) seeds++;
    end
    testsRun++; if (steps != 1) begin testsFailed++; $display("[TB] FAIL step_once: got %0d pulses expected 1", steps); end
    testsRun++; if (seeds != 0) begin testsFailed++; $display("[TB] FAIL step_no_seed: got %0d seed cycles expected 0", seeds); end
    testsRun++; if (termIdx !== 5'd1) begin testsFailed++; $display("[TB] FAIL step_term_idx: got %0d expected 1", termIdx); end
    testsRun++; if (running !== 1'b0) begin testsFailed++; $display("[TB] FAIL step_paused: got %b expected 0", running); end
    steps = 0;
    keyStepN = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (stepEn === 1'b1) steps++;
    end
    keyStepN = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (stepEn === 1'b1) steps++;
    end
    testsRun++; if (steps != 0) begin testsFailed++; $display("[TB] FAIL glitch_no_step: got %0d pulses expected 0", steps); end
    testsRun++; if (termIdx !== 5'd1) begin testsFailed++; $display("[TB] FAIL glitch_term_idx: got %0d expected 1", termIdx); end
  endtask

  task automatic test_run_ticks();
    bit   found = 1'b0;
    logic expStep;
    keyRunN = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (running === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    testsRun++; if (!found) begin testsFailed++; $display("[TB] FAIL run_entry: got running=%b expected 1 within 20 cycles", running); end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 2) keyRunN = 1'b1;
      if (k == 3) keyStepN = 1'b0;
      if (k == 20) keyStepN = 1'b1;
      expStep = (k % 8 == 0);
      testsRun++;
      if (stepEn !== expStep) begin
        testsFailed++;
        $display("[TB] FAIL run_tick cycle %0d: got step_en=%b expected %b", k, stepEn, expStep);
      end
    end
    testsRun++; if (termIdx !== 5'd6) begin testsFailed++; $display("[TB] FAIL run_term_idx: got %0d expected 6", termIdx); end
    testsRun++; if (running !== 1'b1) begin testsFailed++; $display("[TB] FAIL run_still_running: got %b expected 1", running); end
  endtask

  task automatic test_wrap();
    int stepAt[12] = '{8, 16, 24, 32, 40, 48, 65, 73, 81, 89, 97, 114};
    int termAt[12] = '{7, 8, 9, 10, 11, 12, 1, 2, 3, 4, 5, 1};
    logic              expStep;
    logic              expSeed;
    logic [TERM_W-1:0] expTerm;
    for (int j = 1; j <= 115; j++) begin
      @(negedge clk);
      if (j == 100) carryIn = 1'b1;
      if (j == 106) carryIn = 1'b0;
      expStep = 1'b0;
      expTerm = '0;
      for (int idx = 0; idx < 12; idx++) begin
        if (stepAt[idx] == j) begin
          expStep = 1'b1;
          expTerm = TERM_W'(termAt[idx]);
        end
      end
      expSeed = (j == 56) || (j == 105);
      testsRun++;
      if (stepEn !== expStep) begin
        testsFailed++;
        $display("[TB] FAIL wrap_step cycle %0d: got step_en=%b expected %b", j, stepEn, expStep);
      end
      testsRun++;
      if (seedLoad !== expSeed) begin
        testsFailed++;
        $display("[TB] FAIL wrap_seed cycle %0d: got seed_load=%b expected %b", j, seedLoad, expSeed);
      end
      if (expStep || expSeed) begin
        testsRun++;
        if (termIdx !== expTerm) begin
          testsFailed++;
          $display("[TB] FAIL wrap_term cycle %0d: got %0d expected %0d", j, termIdx, expTerm);
        end
        testsRun++;
        if (running !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL wrap_running cycle %0d: got %b expected 1", j, running);
        end
      end
    end
  endtask

  task automatic test_pause_on_tick();
    logic expRun;
    keyRunN = 1'b0;
    for (int m = 1; m <= 15; m++) begin
      @(negedge clk);
      if (m == 10) keyRunN = 1'b1;
      expRun = (m < 7);
      testsRun++;
      if (stepEn !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL pause_tick_step cycle %0d: got step_en=%b expected 0", m, stepEn);
      end
      testsRun++;
      if (running !== expRun) begin
        testsFailed++;
        $display("[TB] FAIL pause_tick_running cycle %0d: got %b expected %b", m, running, expRun);
      end
    end
    testsRun++; if (termIdx !== 5'd1) begin testsFailed++; $display("[TB] FAIL pause_tick_term: got %0d expected 1", termIdx); end
  endtask

  task automatic test_run_step_together();
    int steps = 0;
    repeat (10) @(negedge clk);
    keyRunN = 1'b0;
    keyStepN = 1'b0;
    for (int m = 1; m <= 12; m++) begin
      @(negedge clk);
      if (m == 10) begin
        keyRunN = 1'b1;
        keyStepN = 1'b1;
      end
      if (stepEn === 1'b1) steps++;
    end
    testsRun++; if (steps != 0) begin testsFailed++; $display("[TB] FAIL both_keys_step: got %0d pulses expected 0", steps); end
    testsRun++; if (running !== 1'b1) begin testsFailed++; $display("[TB] FAIL both_keys_running: got %b expected 1", running); end
    testsRun++; if (termIdx !== 5'd1) begin testsFailed++; $display("[TB] FAIL both_keys_term: got %0d expected 1", termIdx); end
  endtask

  task automatic test_reset_mid_run();
    bit found = 1'b0;
    int seeds = 0;
    int steps = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (termIdx === 5'd7) begin
        found = 1'b1;
        break;
      end
    end
    testsRun++; if (!found) begin testsFailed++; $display("[TB] FAIL mid_reach_term7: got term_idx=%0d expected 7 within 100 cycles", termIdx); end
    testsRun++; if (running !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_running_before: got %b expected 1", running); end
    rst = 1'b1;
    @(negedge clk);
    testsRun++; if (stepEn !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_rst_step_en: got %b expected 0", stepEn); end
    testsRun++; if (seedLoad !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_rst_seed_load: got %b expected 0", seedLoad); end
    testsRun++; if (running !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_rst_running: got %b expected 0", running); end
    testsRun++; if (termIdx !== 5'd0) begin testsFailed++; $display("[TB] FAIL mid_rst_term_idx: got %0d expected 0", termIdx); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    testsRun++; if (seedLoad !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_restart_seed: got %b expected 1", seedLoad); end
    repeat (20) begin
      @(negedge clk);
      if (seedLoad === 1'b1) seeds++;
      if (stepEn === 1'b1) steps++;
    end
    testsRun++; if (seeds != 0) begin testsFailed++; $display("[TB] FAIL mid_restart_seed_once: got %0d extra seed cycles expected 0", seeds); end
    testsRun++; if (steps != 0) begin testsFailed++; $display("[TB] FAIL mid_restart_no_step: got %0d pulses expected 0", steps); end
    testsRun++; if (running !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_restart_paused: got %b expected 0", running); end
    testsRun++; if (termIdx !== 5'd0) begin testsFailed++; $display("[TB] FAIL mid_restart_term: got %0d expected 0", termIdx); end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_run_ticks();
    test_wrap();
    test_pause_on_tick();
    test_run_step_together();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
